// File: rtl/rs_age_ordered_pkg.sv
// Shared defaults, entry record and sizing helper for the age-ordered reservation station.
package rs_pkg;
   localparam int DEPTH_D  = 4;
   localparam int TAGW_D   = 4;
   localparam int DATAW_D  = 16;
   localparam int INSTRW_D = 16;
   localparam int NCDB_D   = 4;

   typedef struct packed {
      logic                valid;
      logic [TAGW_D-1:0]   rob_idx;
      logic [INSTRW_D-1:0] instr;
      logic [TAGW_D-1:0]   tag1;
      logic [TAGW_D-1:0]   tag2;
      logic                rdy1;
      logic                rdy2;
      logic [DATAW_D-1:0]  val1;
      logic [DATAW_D-1:0]  val2;
   } rs_entry_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/rs_age_ordered_if.sv
// Dispatch, CDB snoop, issue and status signals of the reservation station.
interface rs_age_ordered_if
   import rs_pkg::*;
#(
   parameter int TAGW   = TAGW_D,
   parameter int DATAW  = DATAW_D,
   parameter int INSTRW = INSTRW_D,
   parameter int NCDB   = NCDB_D,
   parameter int CNTW   = clog2(DEPTH_D + 1)
);
   logic                  flush;
   logic                  in_valid, in_ready;
   logic [TAGW-1:0]       in_rob_idx, in_tag1, in_tag2;
   logic [INSTRW-1:0]     in_instr;
   logic [DATAW-1:0]      in_val1, in_val2;
   logic                  in_rdy1, in_rdy2;
   logic [NCDB-1:0]       cdb_valid;
   logic [NCDB*TAGW-1:0]  cdb_tag;
   logic [NCDB*DATAW-1:0] cdb_data;
   logic                  out_valid, out_ready;
   logic [TAGW-1:0]       out_rob_idx;
   logic [INSTRW-1:0]     out_instr;
   logic [DATAW-1:0]      out_val1, out_val2;
   logic [CNTW-1:0]       count;
   logic                  full, empty;

   modport master (
      output flush, in_valid, in_rob_idx, in_instr, in_tag1, in_tag2, in_val1, in_val2,
             in_rdy1, in_rdy2, cdb_valid, cdb_tag, cdb_data, out_ready,
      input  in_ready, out_valid, out_rob_idx, out_instr, out_val1, out_val2, count, full, empty
   );
   modport slave (
      input  flush, in_valid, in_rob_idx, in_instr, in_tag1, in_tag2, in_val1, in_val2,
             in_rdy1, in_rdy2, cdb_valid, cdb_tag, cdb_data, out_ready,
      output in_ready, out_valid, out_rob_idx, out_instr, out_val1, out_val2, count, full, empty
   );
endinterface

// File: rtl/rs_age_ordered_picker.sv
// Oldest-ready selector: grants the candidate that no other candidate is older than.
module rs_oldest_picker #(
   parameter int DEPTH = 4
) (
   input  logic [DEPTH-1:0]            cand,
   input  logic [DEPTH-1:0][DEPTH-1:0] age,   // age[j][i]: entry j older than entry i
   output logic [DEPTH-1:0]            grant,
   output logic                        any
);
   logic [DEPTH-1:0] older;

   always_comb begin
      grant = '0;
      older = '0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int j = 0; j < DEPTH; j++) older[j] = age[j][i];
         grant[i] = cand[i] & ~|(cand & older);
      end
      any = |cand;
   end
endmodule

// File: rtl/rs_age_ordered.sv
// Reservation station: DEPTH entries, CDB wakeup with write bypass, oldest-ready issue into one output register.
module rs_age_ordered
   import rs_pkg::*;
#(
   parameter int DEPTH  = DEPTH_D,
   parameter int TAGW   = TAGW_D,
   parameter int DATAW  = DATAW_D,
   parameter int INSTRW = INSTRW_D,
   parameter int NCDB   = NCDB_D
) (
   input logic       clk,
   input logic       rst,
   rs_age_ordered_if.slave bus
);
   localparam int CNTW = clog2(DEPTH + 1);

   rs_entry_t [DEPTH-1:0]       ent_q, ent_d;
   rs_entry_t                   in_ent, sel;
   logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
   logic [DEPTH-1:0]            vld, cand, grant, free_oh;
   logic                        any, wr, iss;
   logic                        out_valid_q;
   logic [TAGW-1:0]             out_rob_q;
   logic [INSTRW-1:0]           out_instr_q;
   logic [DATAW-1:0]            out_val1_q, out_val2_q;
   logic [CNTW-1:0]             count_q, cnt_d;
   logic                        full_q, empty_q;

   // Lowest CDB port wins because it is evaluated last; already-resolved operands are left alone.
   function automatic rs_entry_t snoop(input rs_entry_t e, input logic [NCDB-1:0] v,
                                       input logic [NCDB*TAGW-1:0] t, input logic [NCDB*DATAW-1:0] d);
      rs_entry_t r;
      r = e;
      for (int p = NCDB - 1; p >= 0; p--) begin
         if (v[p] && !e.rdy1 && t[p*TAGW +: TAGW] == e.tag1) begin
            r.rdy1 = 1'b1;
            r.val1 = d[p*DATAW +: DATAW];
         end
         if (v[p] && !e.rdy2 && t[p*TAGW +: TAGW] == e.tag2) begin
            r.rdy2 = 1'b1;
            r.val2 = d[p*DATAW +: DATAW];
         end
      end
      return r;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         vld[i]  = ent_q[i].valid;
         cand[i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
      end
      free_oh = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (!vld[i]) begin
            free_oh    = '0;
            free_oh[i] = 1'b1;
         end
   end

   rs_oldest_picker #(.DEPTH(DEPTH)) u_pick (
      .cand (cand),
      .age  (age_q),
      .grant(grant),
      .any  (any)
   );

   assign wr  = bus.in_valid & ~full_q;
   assign iss = any & (~out_valid_q | bus.out_ready);

   always_comb begin
      in_ent         = '0;
      in_ent.valid   = 1'b1;
      in_ent.rob_idx = bus.in_rob_idx;
      in_ent.instr   = bus.in_instr;
      in_ent.tag1    = bus.in_tag1;
      in_ent.tag2    = bus.in_tag2;
      in_ent.rdy1    = bus.in_rdy1;
      in_ent.rdy2    = bus.in_rdy2;
      in_ent.val1    = bus.in_val1;
      in_ent.val2    = bus.in_val2;
      in_ent         = snoop(in_ent, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

      sel   = '0;
      ent_d = ent_q;
      age_d = age_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) sel = ent_q[i];
         if (vld[i]) ent_d[i] = snoop(ent_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
         if (iss && grant[i]) begin
            ent_d[i].valid = 1'b0;
            age_d[i]       = '0;
            for (int j = 0; j < DEPTH; j++) age_d[j][i] = 1'b0;
         end
      end
      // New entry is younger than every entry that survives this edge.
      for (int i = 0; i < DEPTH; i++)
         if (wr && free_oh[i]) begin
            ent_d[i] = in_ent;
            age_d[i] = '0;
            for (int j = 0; j < DEPTH; j++) age_d[j][i] = vld[j] & ~(iss & grant[j]);
         end
      cnt_d = count_q + CNTW'(wr) - CNTW'(iss);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_q       <= '0;
         age_q       <= '0;
         out_valid_q <= 1'b0;
         out_rob_q   <= '0;
         out_instr_q <= '0;
         out_val1_q  <= '0;
         out_val2_q  <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
      end else if (bus.flush) begin
         ent_q       <= '0;
         age_q       <= '0;
         out_valid_q <= 1'b0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
      end else begin
         ent_q   <= ent_d;
         age_q   <= age_d;
         count_q <= cnt_d;
         full_q  <= (cnt_d == CNTW'(DEPTH));
         empty_q <= (cnt_d == '0);
         if (iss) begin
            out_valid_q <= 1'b1;
            out_rob_q   <= sel.rob_idx;
            out_instr_q <= sel.instr;
            out_val1_q  <= sel.val1;
            out_val2_q  <= sel.val2;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = ~full_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_rob_idx = out_rob_q;
   assign bus.out_instr   = out_instr_q;
   assign bus.out_val1    = out_val1_q;
   assign bus.out_val2    = out_val2_q;
   assign bus.count       = count_q;
   assign bus.full        = full_q;
   assign bus.empty       = empty_q;
endmodule

// File: tb/tb_rs_age_ordered.sv
// Directed bench for rs_age_ordered: reset, issue latency, wakeup/bypass, age order, full/stall, flush.
module tb_rs_age_ordered;
   import rs_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;
   logic [3:0] log_q[$];

   always #5 clk = ~clk;

   rs_age_ordered_if bus();
   rs_age_ordered dut (.clk(clk), .rst(rst), .bus(bus.slave));

   // Transfers are committed at the following rising edge.
   always @(negedge clk)
      if (!rst && !bus.flush && bus.out_valid && bus.out_ready) log_q.push_back(bus.out_rob_idx);

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not reach the end");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.cdb_valid = '0;
      bus.flush     = 1'b0;
   endtask

   task automatic drive_wr(input logic [3:0] rob, input logic [3:0] t1, input logic r1, input logic [15:0] v1,
                           input logic [3:0] t2, input logic r2, input logic [15:0] v2);
      bus.in_valid   = 1'b1;
      bus.in_rob_idx = rob;
      bus.in_instr   = {12'hA50, rob};
      bus.in_tag1    = t1;
      bus.in_rdy1    = r1;
      bus.in_val1    = v1;
      bus.in_tag2    = t2;
      bus.in_rdy2    = r2;
      bus.in_val2    = v2;
   endtask

   task automatic cdb_set(input int p, input logic [3:0] t, input logic [15:0] d);
      bus.cdb_valid[p]       = 1'b1;
      bus.cdb_tag[p*4 +: 4]  = t;
      bus.cdb_data[p*16 +: 16] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      bus.out_ready = 1'b1;
      bus.cdb_tag = '0; bus.cdb_data = '0;
      drive_wr(4'h0, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0);
      bus.in_valid = 1'b0;
      #12 rst = 1'b0;
      cyc();
      n_chk++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin n_fail++; $display("FAIL reset_state: out_valid=%b count=%0d, want 0/0", bus.out_valid, bus.count); end
      n_chk++; if (bus.in_ready !== 1'b1 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: in_ready=%b empty=%b full=%b, want 1/1/0", bus.in_ready, bus.empty, bus.full); end
      n_chk++; if (bus.out_rob_idx !== 4'h0 || bus.out_val1 !== 16'h0) begin n_fail++; $display("FAIL reset_payload: rob=%h val1=%h, want 0/0", bus.out_rob_idx, bus.out_val1); end
      bus.out_ready = 1'b0;
      drive_wr(4'hE, 4'h0, 1'b1, 16'h00E1, 4'h0, 1'b1, 16'h00E2);
      cyc();
      idle();
      cyc();
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rob_idx !== 4'hE) begin n_fail++; $display("FAIL pre_rst_issue: out_valid=%b rob=%h, want 1/e", bus.out_valid, bus.out_rob_idx); end
      #2 rst = 1'b1;
      #1;
      n_chk++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0 || bus.in_ready !== 1'b1 || bus.out_rob_idx !== 4'h0) begin
         n_fail++; $display("FAIL async_rst: out_valid=%b count=%0d in_ready=%b rob=%h, want 0/0/1/0", bus.out_valid, bus.count, bus.in_ready, bus.out_rob_idx); end
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      cyc();
   endtask

   task automatic test_ready_issue();
      drive_wr(4'h3, 4'h0, 1'b1, 16'h0011, 4'h0, 1'b1, 16'h0022);
      cyc();
      idle();
      n_chk++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd1) begin n_fail++; $display("FAIL write_lat: out_valid=%b count=%0d, want 0/1", bus.out_valid, bus.count); end
      cyc();
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rob_idx !== 4'h3 || bus.out_instr !== 16'hA503) begin n_fail++; $display("FAIL issue_rob3: out_valid=%b rob=%h instr=%h, want 1/3/a503", bus.out_valid, bus.out_rob_idx, bus.out_instr); end
      n_chk++; if (bus.out_val1 !== 16'h0011 || bus.out_val2 !== 16'h0022 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin
         n_fail++; $display("FAIL issue_vals: val1=%h val2=%h count=%0d empty=%b, want 0011/0022/0/1", bus.out_val1, bus.out_val2, bus.count, bus.empty); end
      cyc();
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain: out_valid=%b, want 0", bus.out_valid); end
   endtask

   task automatic test_wakeup();
      drive_wr(4'h5, 4'h7, 1'b0, 16'hDEAD, 4'h0, 1'b1, 16'h0033);
      cyc();
      idle();
      cyc();
      n_chk++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd1) begin n_fail++; $display("FAIL wait_op: out_valid=%b count=%0d, want 0/1", bus.out_valid, bus.count); end
      cdb_set(2, 4'h7, 16'hBEEF);
      cyc();
      idle();
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL wake_lat: out_valid=%b, want 0", bus.out_valid); end
      cyc();
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rob_idx !== 4'h5 || bus.out_val1 !== 16'hBEEF || bus.out_val2 !== 16'h0033) begin
         n_fail++; $display("FAIL wake_issue: out_valid=%b rob=%h val1=%h val2=%h, want 1/5/beef/0033", bus.out_valid, bus.out_rob_idx, bus.out_val1, bus.out_val2); end
      cyc();
   endtask

   task automatic test_age_order();
      logic [3:0] exp_q[4];
      exp_q = '{4'hF, 4'h2, 4'h1, 4'h4};
      log_q.delete();
      bus.out_ready = 1'b0;
      drive_wr(4'hF, 4'h0, 1'b1, 16'h00F1, 4'h0, 1'b1, 16'h00F2);
      cyc();
      idle();
      cyc();
      drive_wr(4'h2, 4'h0, 1'b1, 16'h0021, 4'h0, 1'b1, 16'h0022);
      cyc();
      drive_wr(4'h1, 4'h6, 1'b0, 16'h0000, 4'h0, 1'b1, 16'h0012);
      cyc();
      idle();
      n_chk++; if (bus.count !== 3'd2 || bus.out_rob_idx !== 4'hF) begin n_fail++; $display("FAIL age_fill: count=%0d rob=%h, want 2/f", bus.count, bus.out_rob_idx); end
      bus.out_ready = 1'b1;
      cdb_set(0, 4'h6, 16'h0066);
      cyc();
      idle();
      bus.out_ready = 1'b0;
      drive_wr(4'h4, 4'h0, 1'b1, 16'h0041, 4'h0, 1'b1, 16'h0042);
      cyc();
      idle();
      cyc();
      n_chk++; if (bus.count !== 3'd2 || bus.out_rob_idx !== 4'h2) begin n_fail++; $display("FAIL age_hold: count=%0d rob=%h, want 2/2", bus.count, bus.out_rob_idx); end
      bus.out_ready = 1'b1;
      cyc();
      n_chk++; if (bus.out_rob_idx !== 4'h1 || bus.out_val1 !== 16'h0066) begin n_fail++; $display("FAIL age_pick: rob=%h val1=%h, want 1/0066", bus.out_rob_idx, bus.out_val1); end
      cyc();
      cyc();
      n_chk++; if (log_q.size() !== 4) begin n_fail++; $display("FAIL age_count: issued=%0d, want 4", log_q.size()); end
      else for (int k = 0; k < 4; k++) begin
         n_chk++; if (log_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL age_seq%0d: rob=%h, want %h", k, log_q[k], exp_q[k]); end
      end
   endtask

   task automatic test_full_stall();
      log_q.delete();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         drive_wr(4'(8 + k), 4'h0, 1'b1, 16'(16'h0100 + k), 4'h0, 1'b1, 16'h0200);
         cyc();
      end
      n_chk++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.in_ready !== 1'b0 || bus.empty !== 1'b0) begin
         n_fail++; $display("FAIL full: count=%0d full=%b in_ready=%b empty=%b, want 4/1/0/0", bus.count, bus.full, bus.in_ready, bus.empty); end
      drive_wr(4'hD, 4'h0, 1'b1, 16'h0D00, 4'h0, 1'b1, 16'h0D00);
      for (int k = 0; k < 3; k++) begin
         cyc();
         n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rob_idx !== 4'h8 || bus.out_val1 !== 16'h0100 || bus.count !== 3'd4) begin
            n_fail++; $display("FAIL stall%0d: out_valid=%b rob=%h val1=%h count=%0d, want 1/8/0100/4", k, bus.out_valid, bus.out_rob_idx, bus.out_val1, bus.count); end
      end
      idle();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         n_chk++; if (bus.count !== 3'(3 - k) || bus.out_rob_idx !== 4'(9 + k)) begin
            n_fail++; $display("FAIL drain%0d: count=%0d rob=%h, want %0d/%h", k, bus.count, bus.out_rob_idx, 3 - k, 9 + k); end
      end
      cyc();
      n_chk++; if (bus.out_valid !== 1'b0 || log_q.size() !== 5) begin n_fail++; $display("FAIL drain_end: out_valid=%b issued=%0d, want 0/5", bus.out_valid, log_q.size()); end
   endtask

   task automatic test_bypass_flush();
      bus.out_ready = 1'b1;
      drive_wr(4'h6, 4'h0, 1'b1, 16'h0001, 4'h9, 1'b0, 16'hDEAD);
      cdb_set(0, 4'h9, 16'h1111);
      cdb_set(3, 4'h9, 16'h2222);
      cyc();
      idle();
      cyc();
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_rob_idx !== 4'h6 || bus.out_val2 !== 16'h1111) begin
         n_fail++; $display("FAIL bypass: out_valid=%b rob=%h val2=%h, want 1/6/1111", bus.out_valid, bus.out_rob_idx, bus.out_val2); end
      cyc();
      drive_wr(4'h7, 4'hA, 1'b0, 16'h0000, 4'hA, 1'b1, 16'h0077);
      cyc();
      idle();
      cdb_set(1, 4'hA, 16'h3333);
      cdb_set(2, 4'hA, 16'h4444);
      cyc();
      idle();
      cyc();
      n_chk++; if (bus.out_rob_idx !== 4'h7 || bus.out_val1 !== 16'h3333 || bus.out_val2 !== 16'h0077) begin
         n_fail++; $display("FAIL wake_prio: rob=%h val1=%h val2=%h, want 7/3333/0077", bus.out_rob_idx, bus.out_val1, bus.out_val2); end
      cyc();
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_wr(4'(1 + k), 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0);
         cyc();
      end
      n_chk++; if (bus.count !== 3'd3 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_flush: count=%0d out_valid=%b, want 3/1", bus.count, bus.out_valid); end
      drive_wr(4'h5, 4'h0, 1'b1, 16'h0, 4'h0, 1'b1, 16'h0);
      bus.flush = 1'b1;
      cyc();
      idle();
      n_chk++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.empty !== 1'b1 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL flush: count=%0d out_valid=%b empty=%b in_ready=%b, want 0/0/1/1", bus.count, bus.out_valid, bus.empty, bus.in_ready); end
      cyc();
      n_chk++; if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_flush: count=%0d out_valid=%b, want 0/0", bus.count, bus.out_valid); end
   endtask

   initial begin
      test_reset();
      test_ready_issue();
      test_wakeup();
      test_age_order();
      test_full_stall();
      test_bypass_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
